ddr3_app_responder: RTL
=======================

Name: ddr3_app_responder

Overview:
- Synthesizable responder for the DDR3 controller application interface: the memory side of the cmd/wr_data/rd_data handshake that DDR3_test drives.
- Substitutes for DDR3_Memory_Interface_Top in simulation and on-board loopback builds.
- Backs accesses with an internal block RAM and emulates calibration, refresh and self-refresh handshakes.
- Lets the traffic generator and display logic be verified without a PHY.

Parameters:
- ADDR_WIDTH, 29, width of addr.
- APP_DATA_WIDTH, 64, beat width of wr_data/rd_data.
- APP_MASK_WIDTH, 8, APP_DATA_WIDTH/8 byte enables.
- MEM_AW, 10, log2 of backing RAM depth in beats.
- ADDR_LSB, 2, addr bit where the beat index starts. Beat index = addr[ADDR_LSB+MEM_AW-1:ADDR_LSB]; upper bits are ignored, so the RAM aliases.
- RD_LATENCY, 4, cycles from read-command pop to rd_data_valid. Minimum 2.
- CMD_DEPTH, 4, command FIFO depth (power of 2).
- WDATA_DEPTH, 4, write-data FIFO depth (power of 2).
- INIT_CYCLES, 64, cycles after reset before init_calib_complete rises.
- REF_CYCLES, 8, cycles the refresh stall lasts.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cmd_en  in  1  command strobe; accepted when cmd_en && cmd_ready.
- cmd  in  3  3'b000 write, 3'b001 read; other codes are illegal.
- addr  in  ADDR_WIDTH  command address.
- cmd_ready  out  1  command can be accepted.
- wr_data_en  in  1  write-data strobe; accepted when wr_data_en && wr_data_rdy.
- wr_data  in  APP_DATA_WIDTH  write beat.
- wr_data_end  in  1  last beat of a burst; must equal wr_data_en.
- wr_data_mask  in  APP_MASK_WIDTH  1 = byte NOT written.
- wr_data_rdy  out  1  write-data FIFO not full.
- rd_data  out  APP_DATA_WIDTH  read beat.
- rd_data_valid  out  1  rd_data is valid this cycle.
- rd_data_end  out  1  equals rd_data_valid (one beat per command).
- ref_req  in  1  refresh request pulse.
- ref_ack  out  1  one-cycle pulse when the refresh stall ends.
- sr_req  in  1  self-refresh request level.
- sr_ack  out  1  high while in self-refresh.
- init_calib_complete  out  1  emulated calibration done.
- cmd_err  out  1  sticky; set by an illegal cmd code or a wr_data_end/wr_data_en mismatch.

Behaviour:
- Reset: all outputs are 0, including cmd_ready, wr_data_rdy and init_calib_complete. FIFOs and pipeline are cleared; RAM contents are retained. Reset asserted mid-operation discards in-flight reads (no valid emitted) and queued writes.
- Init counter: init_calib_complete rises on cycle INIT_CYCLES after rst falls and stays high. Before that, cmd_ready=0 and wr_data_rdy=0.
- FSM states: INIT, RUN, REF, SR_DRAIN, SR.
- INIT -> RUN on counter expiry.
- RUN -> REF on ref_req=1.
  - REF holds cmd_ready=0 for REF_CYCLES cycles, then pulses ref_ack for 1 cycle and returns to RUN.
  - Queued commands keep executing during REF.
  - ref_req arriving while in REF is absorbed (no second ack).
- RUN -> SR_DRAIN on sr_req=1, with cmd_ready=0. When the command FIFO and read pipeline are empty -> SR with sr_ack=1. In SR, sr_req=0 -> RUN with sr_ack=0 the same cycle.
- If ref_req and sr_req arrive together, refresh is served first.
- cmd_ready = state is RUN and command FIFO not full. Combinational from registered state/counts only; no path from cmd_en.
- Command execution, at most one per cycle from the FIFO head:
  - Read pops immediately.
  - Write pops only when the write-data FIFO is non-empty, then pops one data beat and writes the RAM with per-byte masking.
  - Write data may arrive before, with, or after its command. Data order is matched to write-command order.
- Illegal cmd codes are accepted, dropped without execution, and set cmd_err.
- Read path:
  - A popped read enters a RD_LATENCY-stage valid/address pipeline; RAM read is registered.
  - rd_data_valid rises exactly RD_LATENCY cycles after the pop. Order is strictly in-order; no backpressure.
  - Read-after-write to the same beat returns the new data provided the write popped earlier.
- Full/empty boundaries:
  - A full write-data FIFO drops wr_data_rdy the cycle after the fill beat.
  - A simultaneous push and pop at full is allowed for both FIFOs (count unchanged).
  - FIFO pointers wrap modulo depth.

Decomposition:
- Package ddr3_app_pkg holds:
  - CMD_WR/CMD_RD encodings.
  - FSM state enum.
  - Beat-index extraction function.
- Sub-module app_sync_fifo (parameterized width/depth, first-word-fall-through, full/empty/count) is instantiated twice: command FIFO of {cmd, beat index} and write-data FIFO of {mask, data}.

Test Plan:
- Write 0x1122334455667788 at addr 0x40, mask 0 -> read of 0x40 returns 0x1122334455667788 with rd_data_valid exactly RD_LATENCY cycles after the pop and rd_data_end=1.
- Write all-ones to addr 0x80, then write 0 with mask 8'h0F -> read returns 0x00000000FFFFFFFF.
- Issue 4 write commands with no data -> cmd_ready=0 when the FIFO is full. Then supply 4 beats -> all commit in order and reads return the matching beats.
- 8 back-to-back reads -> 8 consecutive rd_data_valid cycles, in order. ref_req mid-stream -> cmd_ready low for 8 cycles and a single ref_ack pulse.
- sr_req with 2 reads pending -> both returned before sr_ack=1. Release sr_req -> sr_ack=0 and cmd_ready=1 the next cycle.
- cmd=3'b101 -> cmd_err=1 and no read data. rst pulse with 2 reads in flight -> no rd_data_valid afterwards and init_calib_complete=0 for 64 cycles.

Source files
------------

// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 application-interface responder:
// command encodings, controller state encoding and address-to-beat mapping.
package ddr3_app_pkg;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RUN,
    ST_REF,
    ST_SR_DRAIN,
    ST_SR
  } state_t;

  // Beat index inside the backing RAM; upper address bits are dropped so the
  // RAM aliases across the full address space.
  function automatic logic [31:0] beat_index(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned aw);
    logic [63:0] shifted;
    shifted = addr >> lsb;
    return shifted[31:0] & ((32'd1 << aw) - 32'd1);
  endfunction

endpackage

// File: rtl/app_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// pop_data whenever empty is low; a push while full is taken only if a pop
// happens in the same cycle, which leaves the count unchanged.
module app_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || pop);

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ddr3_app_responder.sv
// Memory-side model of the DDR3 controller application interface. Commands
// and write beats are queued, executed one per cycle against a block RAM,
// and reads return after a fixed latency. Calibration, refresh and
// self-refresh handshakes are emulated by a small controller FSM.
//
// Handshakes: a command transfers when cmd_en && cmd_ready; a write beat
// transfers when wr_data_en && wr_data_rdy. Neither ready depends on its own
// strobe. Read data has no backpressure: rd_data is valid exactly in the
// cycles rd_data_valid is high.
module ddr3_app_responder
  import ddr3_app_pkg::*;
#(
  parameter int ADDR_WIDTH     = 29,
  parameter int APP_DATA_WIDTH = 64,
  parameter int APP_MASK_WIDTH = 8,
  parameter int MEM_AW         = 10,
  parameter int ADDR_LSB       = 2,
  parameter int RD_LATENCY     = 4,
  parameter int CMD_DEPTH      = 4,
  parameter int WDATA_DEPTH    = 4,
  parameter int INIT_CYCLES    = 64,
  parameter int REF_CYCLES     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_en,
  input  logic [2:0]                cmd,
  input  logic [ADDR_WIDTH-1:0]     addr,
  output logic                      cmd_ready,
  input  logic                      wr_data_en,
  input  logic [APP_DATA_WIDTH-1:0] wr_data,
  input  logic                      wr_data_end,
  input  logic [APP_MASK_WIDTH-1:0] wr_data_mask,
  output logic                      wr_data_rdy,
  output logic [APP_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_data_valid,
  output logic                      rd_data_end,
  input  logic                      ref_req,
  output logic                      ref_ack,
  input  logic                      sr_req,
  output logic                      sr_ack,
  output logic                      init_calib_complete,
  output logic                      cmd_err
);

  localparam int CW     = 3 + MEM_AW;
  localparam int WW     = APP_MASK_WIDTH + APP_DATA_WIDTH;
  localparam int PD     = RD_LATENCY - 1;
  localparam int INIT_W = $clog2(INIT_CYCLES) + 1;
  localparam int REF_W  = $clog2(REF_CYCLES) + 1;
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_CYCLES - 1);
  localparam logic [REF_W-1:0]  REF_LAST  = REF_W'(REF_CYCLES - 1);

  state_t              state;
  logic [INIT_W-1:0]   init_cnt;
  logic [REF_W-1:0]    ref_cnt;

  logic [MEM_AW-1:0]   cmd_idx;
  logic                cmd_push;
  logic                cmd_pop;
  logic [CW-1:0]       cmd_head;
  logic                cmd_full;
  logic                cmd_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic [2:0]          head_op;
  logic [MEM_AW-1:0]   head_idx;

  logic                wd_push;
  logic                wd_pop;
  logic [WW-1:0]       wd_head;
  logic                wd_full;
  logic                wd_empty;
  logic [$clog2(WDATA_DEPTH):0] wd_count;
  logic [APP_MASK_WIDTH-1:0] wd_mask;
  logic [APP_DATA_WIDTH-1:0] wd_data;

  logic                rd_issue;
  logic                rd_busy;
  logic [PD-1:0]       rd_vld_pipe;
  logic [MEM_AW-1:0]   rd_idx_pipe [PD];

  logic [APP_DATA_WIDTH-1:0] mem [2**MEM_AW];

  logic                unused_status;

  assign cmd_idx     = MEM_AW'(beat_index(64'(addr), ADDR_LSB, MEM_AW));
  assign cmd_ready   = (state == ST_RUN) && !cmd_full;
  assign wr_data_rdy = init_calib_complete && !wd_full;
  assign cmd_push    = cmd_en && cmd_ready;
  assign wd_push     = wr_data_en && wr_data_rdy;

  assign head_op  = cmd_head[CW-1:MEM_AW];
  assign head_idx = cmd_head[MEM_AW-1:0];
  assign wd_mask  = wd_head[WW-1:APP_DATA_WIDTH];
  assign wd_data  = wd_head[APP_DATA_WIDTH-1:0];

  // A write waits at the head until its data beat is present; reads and
  // illegal codes leave immediately (illegal codes do nothing).
  assign cmd_pop  = !rst && !cmd_empty && ((head_op != CMD_WR) || !wd_empty);
  assign wd_pop   = cmd_pop && (head_op == CMD_WR);
  assign rd_issue = cmd_pop && (head_op == CMD_RD);
  assign rd_busy  = (|rd_vld_pipe) || rd_data_valid;

  assign rd_data_end   = rd_data_valid;
  assign unused_status = ^{cmd_count, wd_count};

  app_sync_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (cmd_push),
    .push_data ({cmd, cmd_idx}),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  app_sync_fifo #(.WIDTH(WW), .DEPTH(WDATA_DEPTH)) u_wd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (wd_push),
    .push_data ({wr_data_mask, wr_data}),
    .pop       (wd_pop),
    .pop_data  (wd_head),
    .full      (wd_full),
    .empty     (wd_empty),
    .count     (wd_count)
  );

  // Controller FSM: calibration wait, refresh stall and self-refresh entry/exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_INIT;
      init_cnt            <= '0;
      ref_cnt             <= '0;
      init_calib_complete <= 1'b0;
      ref_ack             <= 1'b0;
      sr_ack              <= 1'b0;
    end else begin
      ref_ack <= 1'b0;
      unique case (state)
        ST_INIT: begin
          if (init_cnt == INIT_LAST) begin
            state               <= ST_RUN;
            init_calib_complete <= 1'b1;
          end else begin
            init_cnt <= init_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (ref_req) begin
            state   <= ST_REF;
            ref_cnt <= '0;
          end else if (sr_req) begin
            state <= ST_SR_DRAIN;
          end
        end
        ST_REF: begin
          if (ref_cnt == REF_LAST) begin
            state   <= ST_RUN;
            ref_ack <= 1'b1;
          end else begin
            ref_cnt <= ref_cnt + 1'b1;
          end
        end
        ST_SR_DRAIN: begin
          if (cmd_empty && !rd_busy) begin
            state  <= ST_SR;
            sr_ack <= 1'b1;
          end
        end
        ST_SR: begin
          if (!sr_req) begin
            state  <= ST_RUN;
            sr_ack <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_err <= 1'b0;
    end else if ((cmd_push && (cmd != CMD_WR) && (cmd != CMD_RD)) ||
                 (wr_data_en != wr_data_end)) begin
      cmd_err <= 1'b1;
    end
  end

  // Byte-masked RAM write when a write command and its beat pop together.
  always_ff @(posedge clk) begin
    if (wd_pop) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!wd_mask[b]) mem[head_idx][b*8 +: 8] <= wd_data[b*8 +: 8];
      end
    end
  end

  // Read-valid shift register; cleared by reset so in-flight reads vanish.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_pipe <= '0;
    end else begin
      rd_vld_pipe[0] <= rd_issue;
      for (int k = 1; k < PD; k++) rd_vld_pipe[k] <= rd_vld_pipe[k-1];
    end
  end

  // Read-address shift register travelling alongside the valid bits.
  always_ff @(posedge clk) begin
    rd_idx_pipe[0] <= head_idx;
    for (int k = 1; k < PD; k++) rd_idx_pipe[k] <= rd_idx_pipe[k-1];
  end

  // Registered RAM read feeding the read-data outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_valid <= 1'b0;
      rd_data       <= '0;
    end else begin
      rd_data_valid <= rd_vld_pipe[PD-1];
      if (rd_vld_pipe[PD-1]) rd_data <= mem[rd_idx_pipe[PD-1]];
    end
  end

endmodule
